// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types and constants for the data-memory arbiter
package dmem_arb_pkg;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} arb_state_t;

  typedef logic port_id_t;

  localparam port_id_t PORT_CPU = 1'b0;
  localparam port_id_t PORT_AUX = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// rtl/rr_pick2.sv - combinational two-way round-robin winner select with lock override
module rr_pick2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  port_id_t   last_grant,
  input  logic       lock_pending,
  input  port_id_t   lock_port,
  output logic       valid,
  output port_id_t   winner
);

  // A pending lock beats everything; otherwise a lone requester wins, and a tie goes to the port not served last.
  always_comb begin
    valid  = |req;
    winner = PORT_CPU;
    if (lock_pending && req[lock_port]) begin
      winner = lock_port;
    end else if (req == 2'b10) begin
      winner = PORT_AUX;
    end else if (req == 2'b11) begin
      winner = ~last_grant;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port req/ack arbiter for the single-ported data memory
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              we0,
  input  logic              lock0,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  input  logic              we1,
  input  logic              lock1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              grant_id
);

  arb_state_t state;
  arb_state_t next_state;

  // Only the word address is kept; the two byte-offset bits never reach the memory.
  logic [ADDR_W-3:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              we_q;
  logic              lock_q;
  logic [DATA_W-1:0] rdata_q;
  port_id_t          last_grant;
  logic              lock_pending;

  logic              pick_valid;
  port_id_t          pick_winner;

  logic [ADDR_W-3:0] win_addr;
  logic [DATA_W-1:0] win_wdata;
  logic              win_we;
  logic              win_lock;

  // The lock always belongs to the port served just before, which is last_grant.
  rr_pick2 u_pick (
    .req          ({req1, req0}),
    .last_grant   (last_grant),
    .lock_pending (lock_pending),
    .lock_port    (last_grant),
    .valid        (pick_valid),
    .winner       (pick_winner)
  );

  assign win_addr  = (pick_winner == PORT_AUX) ? addr1[ADDR_W-1:2] : addr0[ADDR_W-1:2];
  assign win_wdata = (pick_winner == PORT_AUX) ? wdata1 : wdata0;
  assign win_we    = (pick_winner == PORT_AUX) ? we1 : we0;
  assign win_lock  = (pick_winner == PORT_AUX) ? lock1 : lock0;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Payload capture, grant bookkeeping, read capture and lock lifetime.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q       <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      lock_q       <= 1'b0;
      rdata_q      <= '0;
      grant_id     <= PORT_CPU;
      last_grant   <= PORT_AUX;
      lock_pending <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // The lock only survives a single IDLE cycle, used or not.
          lock_pending <= 1'b0;
          if (pick_valid) begin
            addr_q     <= win_addr;
            wdata_q    <= win_wdata;
            we_q       <= win_we;
            lock_q     <= win_lock;
            grant_id   <= pick_winner;
            last_grant <= pick_winner;
          end
        end
        ACCESS: begin
          if (!we_q) begin
            rdata_q <= mem_rdata;
          end
        end
        RESP: begin
          lock_pending <= lock_q;
        end
        default: begin
        end
      endcase
    end
  end

  // Next-state and output decode; acks and read data come straight from state so a reset kills them at once.
  always_comb begin
    next_state = state;
    ack0       = 1'b0;
    ack1       = 1'b0;
    rdata0     = '0;
    rdata1     = '0;
    mem_we     = 1'b0;
    busy       = (state != IDLE);
    mem_addr   = {addr_q, 2'b00};
    mem_wdata  = wdata_q;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          next_state = ACCESS;
        end
      end
      ACCESS: begin
        mem_we     = we_q;
        next_state = RESP;
      end
      RESP: begin
        if (grant_id == PORT_AUX) begin
          ack1   = 1'b1;
          rdata1 = rdata_q;
        end else begin
          ack0   = 1'b1;
          rdata0 = rdata_q;
        end
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

  logic        clk;
  logic        rst;
  logic        req0, req1, we0, we1, lock0, lock1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        ack0, ack1;
  logic [31:0] rdata0, rdata1;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we, busy, grant_id;

  int checks;
  int errors;

  // Memory model: unwritten words read back as 0xA5000000 | word index.
  logic [31:0] mem     [0:4095];
  logic        written [0:4095];
  logic [11:0] mem_idx;

  assign mem_idx   = mem_addr[13:2];
  assign mem_rdata = (written[mem_idx] === 1'b1) ? mem[mem_idx] : (32'hA500_0000 | {20'd0, mem_idx});

  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_idx]     <= mem_wdata;
      written[mem_idx] <= 1'b1;
    end
  end

  dmem_arbiter #(.DATA_W(32), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .addr0(addr0), .wdata0(wdata0), .we0(we0), .lock0(lock0), .ack0(ack0), .rdata0(rdata0),
    .req1(req1), .addr1(addr1), .wdata1(wdata1), .we1(we1), .lock1(lock1), .ack1(ack1), .rdata1(rdata1),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .busy(busy), .grant_id(grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0; lock0 = 0; lock1 = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
  endtask

  task automatic test_reset;
    step; step;
    checks++; if (ack0 !== 1'b0) begin errors++; $display("FAIL rst_ack0: got %b want 0", ack0); end
    checks++; if (ack1 !== 1'b0) begin errors++; $display("FAIL rst_ack1: got %b want 0", ack1); end
    checks++; if (rdata0 !== 32'h0) begin errors++; $display("FAIL rst_rdata0: got %h want 0", rdata0); end
    checks++; if (rdata1 !== 32'h0) begin errors++; $display("FAIL rst_rdata1: got %h want 0", rdata1); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we: got %b want 0", mem_we); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (grant_id !== 1'b0) begin errors++; $display("FAIL rst_grant: got %b want 0", grant_id); end
    // Reset asserted mid-stream, while an access is in flight.
    rst = 0; req0 = 1; addr0 = 32'h4;
    step;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_pre: got %b want 1", busy); end
    rst = 1;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", busy); end
    checks++; if (ack0 !== 1'b0) begin errors++; $display("FAIL midrst_ack0: got %b want 0", ack0); end
    req0 = 0;
    step;
    rst = 0; req0 = 1; addr0 = 32'h4;
    step;
    checks++; if (ack0 !== 1'b0) begin errors++; $display("FAIL rel_ack0_early: got %b want 0", ack0); end
    step;
    checks++; if (ack0 !== 1'b1) begin errors++; $display("FAIL rel_ack0: got %b want 1", ack0); end
    checks++; if (rdata0 !== 32'hA500_0001) begin errors++; $display("FAIL rel_rdata0: got %h want a5000001", rdata0); end
    req0 = 0;
    step;
  endtask

  task automatic test_write_read;
    req0 = 1; we0 = 1; addr0 = 32'h1003; wdata0 = 32'hDEAD_BEEF;
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL wr_we_idle: got %b want 0", mem_we); end
    step;
    checks++; if (mem_addr !== 32'h1000) begin errors++; $display("FAIL wr_addr: got %h want 00001000", mem_addr); end
    checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL wr_we_access: got %b want 1", mem_we); end
    checks++; if (mem_wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wr_wdata: got %h want deadbeef", mem_wdata); end
    step;
    checks++; if (ack0 !== 1'b1) begin errors++; $display("FAIL wr_ack0: got %b want 1", ack0); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL wr_we_resp: got %b want 0", mem_we); end
    we0 = 0; addr0 = 32'h1000;
    step;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rd_busy_idle: got %b want 0", busy); end
    checks++; if (mem[12'h400] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wr_mem: got %h want deadbeef", mem[12'h400]); end
    step; step;
    checks++; if (ack0 !== 1'b1) begin errors++; $display("FAIL rd_ack0: got %b want 1", ack0); end
    checks++; if (rdata0 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_rdata0: got %h want deadbeef", rdata0); end
    checks++; if (ack1 !== 1'b0) begin errors++; $display("FAIL rd_ack1: got %b want 0", ack1); end
    checks++; if (rdata1 !== 32'h0) begin errors++; $display("FAIL rd_rdata1: got %h want 0", rdata1); end
    req0 = 0;
    step;
  endtask

  task automatic test_contention;
    logic exp0, exp1;
    rst = 1; step; rst = 0;
    addr0 = 32'h8; addr1 = 32'hC; req0 = 1; req1 = 1;
    for (int c = 0; c < 12; c++) begin
      exp0 = (c == 2) || (c == 8);
      exp1 = (c == 5) || (c == 11);
      checks++; if (ack0 !== exp0) begin errors++; $display("FAIL cont_ack0 c=%0d: got %b want %b", c, ack0, exp0); end
      checks++; if (ack1 !== exp1) begin errors++; $display("FAIL cont_ack1 c=%0d: got %b want %b", c, ack1, exp1); end
      if (exp0) begin
        checks++; if (rdata0 !== 32'hA500_0002) begin errors++; $display("FAIL cont_rdata0 c=%0d: got %h want a5000002", c, rdata0); end
      end
      if (exp1) begin
        checks++; if (rdata1 !== 32'hA500_0003) begin errors++; $display("FAIL cont_rdata1 c=%0d: got %h want a5000003", c, rdata1); end
      end
      if (c % 3 == 1) begin
        checks++; if (grant_id !== ((c % 6) == 4)) begin errors++; $display("FAIL cont_grant c=%0d: got %b want %b", c, grant_id, (c % 6) == 4); end
      end
      if (c == 11) begin
        req0 = 0; req1 = 0;
      end
      step;
    end
  endtask

  task automatic test_lock;
    // Port 1 read with lock, port 0 arrives meanwhile; port 1's follow-up write must win the tie.
    req1 = 1; addr1 = 32'h10; we1 = 0; lock1 = 1;
    step;
    checks++; if (grant_id !== 1'b1) begin errors++; $display("FAIL lock_g1: got %b want 1", grant_id); end
    req0 = 1; addr0 = 32'h14; we0 = 0;
    step;
    checks++; if (ack1 !== 1'b1) begin errors++; $display("FAIL lock_ack1: got %b want 1", ack1); end
    checks++; if (rdata1 !== 32'hA500_0004) begin errors++; $display("FAIL lock_rdata1: got %h want a5000004", rdata1); end
    we1 = 1; addr1 = 32'h18; wdata1 = 32'h1234_5678; lock1 = 0;
    step; step;
    checks++; if (grant_id !== 1'b1) begin errors++; $display("FAIL lock_g2: got %b want 1", grant_id); end
    checks++; if (mem_addr !== 32'h18) begin errors++; $display("FAIL lock_addr: got %h want 00000018", mem_addr); end
    checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL lock_we: got %b want 1", mem_we); end
    step;
    checks++; if (ack1 !== 1'b1) begin errors++; $display("FAIL lock_ack1b: got %b want 1", ack1); end
    checks++; if (ack0 !== 1'b0) begin errors++; $display("FAIL lock_ack0b: got %b want 0", ack0); end
    req1 = 0; we1 = 0;
    step; step;
    checks++; if (grant_id !== 1'b0) begin errors++; $display("FAIL lock_g3: got %b want 0", grant_id); end
    step;
    checks++; if (ack0 !== 1'b1) begin errors++; $display("FAIL lock_ack0c: got %b want 1", ack0); end
    checks++; if (rdata0 !== 32'hA500_0005) begin errors++; $display("FAIL lock_rdata0: got %h want a5000005", rdata0); end
    checks++; if (mem[6] !== 32'h1234_5678) begin errors++; $display("FAIL lock_mem: got %h want 12345678", mem[6]); end
    req0 = 0;
    step;
    // Lock lost: locked port silent in the first IDLE, port 0 takes it.
    req1 = 1; addr1 = 32'h10; lock1 = 1;
    step;
    req0 = 1; addr0 = 32'h14;
    step;
    checks++; if (ack1 !== 1'b1) begin errors++; $display("FAIL lost_ack1: got %b want 1", ack1); end
    req1 = 0; lock1 = 0;
    step; step;
    checks++; if (grant_id !== 1'b0) begin errors++; $display("FAIL lost_grant: got %b want 0", grant_id); end
    step;
    checks++; if (ack0 !== 1'b1) begin errors++; $display("FAIL lost_ack0: got %b want 1", ack0); end
    checks++; if (ack1 !== 1'b0) begin errors++; $display("FAIL lost_ack1b: got %b want 0", ack1); end
    req0 = 0;
    step;
  endtask

  task automatic test_reset_write;
    req0 = 1; we0 = 1; addr0 = 32'h2000; wdata0 = 32'hCAFE_F00D;
    step;
    checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL rw_we_pre: got %b want 1", mem_we); end
    rst = 1;
    #1;
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rw_we_abort: got %b want 0", mem_we); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rw_busy: got %b want 0", busy); end
    req0 = 0; we0 = 0;
    step;
    checks++; if (written[12'h800] === 1'b1) begin errors++; $display("FAIL rw_mem: got %h want a5000800", mem[12'h800]); end
    checks++; if (ack0 !== 1'b0) begin errors++; $display("FAIL rw_ack0: got %b want 0", ack0); end
    rst = 0;
    step;
    checks++; if (ack0 !== 1'b0) begin errors++; $display("FAIL rw_ack0b: got %b want 0", ack0); end
    // Reset during RESP must swallow the ack.
    req0 = 1; addr0 = 32'h20;
    step; step;
    checks++; if (ack0 !== 1'b1) begin errors++; $display("FAIL rr_ack0_pre: got %b want 1", ack0); end
    rst = 1;
    #1;
    checks++; if (ack0 !== 1'b0) begin errors++; $display("FAIL rr_ack0: got %b want 0", ack0); end
    checks++; if (rdata0 !== 32'h0) begin errors++; $display("FAIL rr_rdata0: got %h want 0", rdata0); end
    req0 = 0;
    step;
    rst = 0;
    step;
  endtask

  task automatic test_payload_change;
    req0 = 1; we0 = 0; addr0 = 32'h20;
    step;
    checks++; if (mem_addr !== 32'h20) begin errors++; $display("FAIL pc_addr: got %h want 00000020", mem_addr); end
    addr0 = 32'h40;
    #1;
    checks++; if (mem_addr !== 32'h20) begin errors++; $display("FAIL pc_addr_hold: got %h want 00000020", mem_addr); end
    step;
    checks++; if (ack0 !== 1'b1) begin errors++; $display("FAIL pc_ack0: got %b want 1", ack0); end
    checks++; if (rdata0 !== 32'hA500_0008) begin errors++; $display("FAIL pc_rdata0: got %h want a5000008", rdata0); end
    req0 = 0;
    step;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    idle_inputs;
    rst = 1;
    test_reset;
    test_write_read;
    test_contention;
    test_lock;
    test_reset_write;
    test_payload_change;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
